// File: rtl/chunked_add_pkg.sv
// chunked_add_pkg: shared types and constants for the chunked sequential adder.
//   state_e         - sequencer state encoding (idle / run / done)
//   DefaultWidth    - default operand width
//   DefaultChunk    - default slice width fed to the chunk adder per cycle
//   calc_nchunk     - number of slices in one operand
//   calc_idx_width  - width of the slice index (at least 1 bit)
package chunked_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultChunk = 4;

  function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  function automatic int unsigned calc_idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? int'($clog2(nchunk)) : 1;
  endfunction

endpackage

// File: rtl/chunked_add_seq_if.sv
// chunked_add_seq_if: operand/result handshake bundle for chunked_add_seq.
//   in_valid/in_ready   - operand handshake (a, b, c_in)
//   out_valid/out_ready - result handshake (sum, c_out, ovf when present)
//   busy                - sequencer is in run or done
// Optional: CHUNKED_ADD_OVF_EN adds the signed-overflow flag ovf.
interface chunked_add_seq_if #(
  parameter int unsigned WIDTH = chunked_add_pkg::DefaultWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             busy;
`ifdef CHUNKED_ADD_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy, ovf
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy, ovf
  );
`else
  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );
  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );
`endif
endinterface

// File: rtl/chunk_adder.sv
// chunk_adder: combinational CHUNK-bit ripple adder built from per-bit full adders.
//   a, b   - slice operands
//   c_in   - carry into bit 0
//   s      - slice sum
//   c_out  - carry out of the slice MSB
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out
);

  // Each stage owns its carry signals so the chain is not one self-dependent vector.
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    logic w_ci;
    logic w_co;
    if (i == 0) begin : g_first
      assign w_ci = c_in;
    end else begin : g_next
      assign w_ci = g_fa[i-1].w_co;
    end
    assign s[i] = a[i] ^ b[i] ^ w_ci;
    assign w_co = (a[i] & b[i]) | (w_ci & (a[i] ^ b[i]));
  end

  assign c_out = g_fa[CHUNK-1].w_co;

endmodule

// File: rtl/chunked_add_seq.sv
// chunked_add_seq: multi-cycle WIDTH-bit adder that walks one CHUNK-bit slice per cycle
// through a single chunk_adder, least significant slice first, carrying between slices.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - chunked_add_seq_if slave: operand handshake in, result handshake out, busy
// Optional: define CHUNKED_ADD_OVF_EN to produce bus.ovf (two's-complement overflow).
module chunked_add_seq
  import chunked_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CHUNK = DefaultChunk
) (
  input  logic             clk,
  input  logic             rst,
  chunked_add_seq_if.slave bus
);

  localparam int unsigned NCHUNK  = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW    = calc_idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IdxLast = IDXW'(NCHUNK - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_c_out;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [IDXW-1:0]  r_idx;

  logic [CHUNK-1:0] w_sa;
  logic [CHUNK-1:0] w_sb;
  logic [CHUNK-1:0] w_ss;
  logic             w_sc;

  assign w_sa = r_a[r_idx*CHUNK +: CHUNK];
  assign w_sb = r_b[r_idx*CHUNK +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a     (w_sa),
    .b     (w_sb),
    .c_in  (r_carry),
    .s     (w_ss),
    .c_out (w_sc)
  );

`ifdef CHUNKED_ADD_OVF_EN
  logic r_ovf;
  logic w_ovf;
  // Carry into the MSB is recovered from the MSB's own sum bit: a ^ b ^ s.
  assign w_ovf   = w_sa[CHUNK-1] ^ w_sb[CHUNK-1] ^ w_ss[CHUNK-1] ^ w_sc;
  assign bus.ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_c_out     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
`ifdef CHUNKED_ADD_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid && r_in_ready) begin
            r_a        <= bus.a;
            r_b        <= bus.b;
            r_carry    <= bus.c_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= StRun;
          end
        end
        StRun: begin
          r_sum[r_idx*CHUNK +: CHUNK] <= w_ss;
          r_carry <= w_sc;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == IdxLast) begin
            r_c_out     <= w_sc;
`ifdef CHUNKED_ADD_OVF_EN
            r_ovf       <= w_ovf;
`endif
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_c_out;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_chunked_add_seq.sv
// tb_chunked_add_seq: self-checking bench for chunked_add_seq.
// Main instance 16/4 gets directed and random operations; a 4/4 instance (one slice)
// is swept over every {a, b, c_in}. Expected results come from plain integer addition.
// Define CHUNKED_ADD_OVF_EN to also check the overflow flag.
module tb_chunked_add_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_add_seq_if #(.WIDTH(16)) bus ();
  chunked_add_seq_if #(.WIDTH(4))  bus_s ();

  chunked_add_seq #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  chunked_add_seq #(
    .WIDTH (4),
    .CHUNK (4)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int n_pass   = 0;
  int n_checks = 0;
  int n_acc_s  = 0;
  int n_res_s  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + 17'(c);
  endfunction

  // Signed overflow: carry into bit 15 differs from carry out of bit 15.
  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [15:0] low;
    logic [16:0] full;
    low  = {1'b0, a[14:0]} + {1'b0, b[14:0]} + 16'(c);
    full = ref_add(a, b, c);
    return low[15] ^ full[16];
  endfunction

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = c;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out16(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Full operation with out_ready high; returns to idle before exiting.
  task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic c);
    int lat;
    logic [16:0] exp;
    exp = ref_add(a, b, c);
    drive16(a, b, c);
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_in_ready_run"}, 32'(bus.in_ready), 32'd0);
    wait_out16(lat);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp[15:0]));
    check({tag, "_c_out"}, 32'(bus.c_out), 32'(exp[16]));
`ifdef CHUNKED_ADD_OVF_EN
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(ref_ovf(a, b, c)));
`endif
    tick();
    check({tag, "_idle"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int lat = 0;
    logic [4:0] exp;
    exp = {1'b0, a} + {1'b0, b} + 5'(c);
    bus_s.in_valid = 1'b1;
    bus_s.a        = a;
    bus_s.b        = b;
    bus_s.c_in     = c;
    tick();
    n_acc_s++;
    bus_s.in_valid = 1'b0;
    while (bus_s.out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    if (bus_s.out_valid === 1'b1) n_res_s++;
    check("s_latency", 32'(lat), 32'd1);
    check("s_result", 32'({bus_s.c_out, bus_s.sum}), 32'(exp));
    tick();
  endtask

  initial begin
    int lat;
    logic [16:0] held;
    logic [15:0] ra, rb;
    logic        rc;

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.c_in       = 1'b0;
    bus.out_ready  = 1'b1;
    bus_s.in_valid = 1'b0;
    bus_s.a        = '0;
    bus_s.b        = '0;
    bus_s.c_in     = 1'b0;
    bus_s.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
`ifdef CHUNKED_ADD_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

    // Directed arithmetic
    op16("basic", 16'h1234, 16'h1111, 1'b0);
    op16("ripple_b1", 16'hFFFF, 16'h0001, 1'b0);
    op16("ripple_cin", 16'hFFFF, 16'h0000, 1'b1);
    op16("zero", 16'h0000, 16'h0000, 1'b0);

    // Backpressure: result held, new operands ignored
    bus.out_ready = 1'b0;
    held = ref_add(16'hBEEF, 16'h1234, 1'b1);
    drive16(16'hBEEF, 16'h1234, 1'b1);
    wait_out16(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = 16'($urandom);
      bus.b        = 16'($urandom);
      bus.c_in     = 1'($urandom);
      check("bp_sum_hold", 32'(bus.sum), 32'(held[15:0]));
      check("bp_c_out_hold", 32'(bus.c_out), 32'(held[16]));
      check("bp_flags", {30'd0, bus.out_valid, bus.in_ready}, 32'b10);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
    check("bp_sum_kept", 32'(bus.sum), 32'(held[15:0]));
    tick();
    check("bp_not_captured", 32'(bus.busy), 32'd0);

    // Reset one cycle into run discards the pending result
    drive16(16'hAAAA, 16'h5555, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_flags", {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
    check("mid_rst_sum", 32'(bus.sum), 32'd0);
    check("mid_rst_c_out", 32'(bus.c_out), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("mid_rst_no_valid", 32'(bus.out_valid), 32'd0);
    op16("post_rst", 16'h0003, 16'h0004, 1'b0);

`ifdef CHUNKED_ADD_OVF_EN
    op16("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
    op16("ovf_neg", 16'h8000, 16'h8000, 1'b0);
    op16("ovf_none", 16'h0001, 16'h0001, 1'b0);
`endif

    // Random operations against the integer model
    for (int i = 0; i < 60; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      op16("rand", ra, rb, rc);
    end

    // Single-slice instance: every {c_in, b, a}
    for (int x = 0; x < 512; x++) begin
      op4(4'(x), 4'(x >> 4), 1'(x >> 8));
    end
    check("s_result_count", 32'(n_res_s), 32'(n_acc_s));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
